// File: rtl/regfile_pkg.sv
// Shared modify-op encodings for the parametrised register file.
package regfile_pkg;

   localparam logic [1:0] MOP_NOP = 2'b00;
   localparam logic [1:0] MOP_INC = 2'b01;
   localparam logic [1:0] MOP_DEC = 2'b10;
   localparam logic [1:0] MOP_CLR = 2'b11;

endpackage

// File: rtl/rf_read_port.sv
// One tristate read port: address mux, optional write-through compare, Z driver.
// Write-through is enabled by defining REGFILE_BYPASS_EN.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
   input  logic                          oe,
   input  logic [ADDR_W-1:0]             raddr,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             waddr,
   input  logic [DATA_W-1:0]             wdata,
   output logic [DATA_W-1:0]             rdata
);

   logic [DATA_W-1:0] sel_s;

`ifdef REGFILE_BYPASS_EN
   // Select stored word, or the word being written this cycle to the same address
   always_comb begin
      sel_s = regs_flat[raddr*DATA_W +: DATA_W];
      if (we && (raddr == waddr)) begin
         sel_s = wdata;
      end else begin
         sel_s = regs_flat[raddr*DATA_W +: DATA_W];
      end
   end
`else
   logic unused_s;
   assign unused_s = ^{we, waddr, wdata};

   // Select stored word; a concurrent write is not visible until the next cycle
   always_comb begin
      sel_s = regs_flat[raddr*DATA_W +: DATA_W];
   end
`endif

   assign rdata = oe ? sel_s : {DATA_W{1'bz}};

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two tristate read ports, INC/DEC/CLR modify port.
// Optional write-through on the read ports via REGFILE_BYPASS_EN.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        mop,
   input  logic [ADDR_W-1:0] maddr,
   input  logic              oe_a,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              oe_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] tap0,
   output logic [DATA_W-1:0] tap1,
   output logic              wrap
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0]      regs_r [NREG];
   logic                   wrap_r;
   logic [DATA_W-1:0]      cur_s;
   logic [DATA_W-1:0]      mod_val_s;
   logic                   mod_wrap_s;
   logic                   mod_en_s;
   logic [NREG*DATA_W-1:0] regs_flat_s;

   // Modify result and wrap detect; a same-address write cancels the modify
   always_comb begin
      cur_s      = regs_r[maddr];
      mod_val_s  = cur_s;
      mod_wrap_s = 1'b0;
      case (mop)
         MOP_INC: begin
            mod_val_s  = cur_s + DATA_W'(1);
            mod_wrap_s = &cur_s;
         end
         MOP_DEC: begin
            mod_val_s  = cur_s - DATA_W'(1);
            mod_wrap_s = ~|cur_s;
         end
         MOP_CLR: begin
            mod_val_s  = {DATA_W{1'b0}};
            mod_wrap_s = 1'b0;
         end
         default: begin
            mod_val_s  = cur_s;
            mod_wrap_s = 1'b0;
         end
      endcase
      if ((mop != MOP_NOP) && !(we && (waddr == maddr))) begin
         mod_en_s = 1'b1;
      end else begin
         mod_en_s = 1'b0;
      end
   end

   // Storage update: write port has priority over the modify port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         wrap_r <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (we && (waddr == ADDR_W'(i))) begin
               regs_r[i] <= wdata;
            end else if (mod_en_s && (maddr == ADDR_W'(i))) begin
               regs_r[i] <= mod_val_s;
            end
         end
         wrap_r <= mod_en_s & mod_wrap_s;
      end
   end

   // Flatten storage for the read-port sub-modules
   always_comb begin
      regs_flat_s = {(NREG*DATA_W){1'b0}};
      for (int i = 0; i < NREG; i++) begin
         regs_flat_s[i*DATA_W +: DATA_W] = regs_r[i];
      end
   end

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .regs_flat (regs_flat_s),
      .oe        (oe_a),
      .raddr     (raddr_a),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .rdata     (rdata_a)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .regs_flat (regs_flat_s),
      .oe        (oe_b),
      .raddr     (raddr_b),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .rdata     (rdata_b)
   );

   assign tap0 = regs_r[0];
   assign tap1 = regs_r[1];
   assign wrap = wrap_r;

endmodule
